multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine over one shared instruction/data memory port with a req/ready handshake.
- Drives PC/IR write enables, memory port, register-file write, ALU operand selects, ALU op and immediate select from the latched instruction.
- Counts retired instructions and traps on illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// instruction/data memory port with a req/ready handshake. Counts retired
// instructions and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opCode,
    input  logic [2:0]           func3,
    input  logic [6:0]           func7,
    input  logic                 brTaken,
    input  logic                 memReady,
    output logic                 memReq,
    output logic                 memWr,
    output logic                 addrSrc,
    output logic [2:0]           dmCtrl,
    output logic                 irWr,
    output logic                 pcWr,
    output logic                 pcSrc,
    output logic                 ruWr,
    output logic [1:0]           ruDataWrSrc,
    output logic                 aluASrc,
    output logic                 aluBSrc,
    output logic [3:0]           aluOp,
    output logic [2:0]           immSrc,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trapCause
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Wait counter only needs to reach the limit; it saturates at all-ones.
    localparam int              WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;
    logic              entering_wait;
    logic              trap_set;
    logic [1:0]        trap_cause_next;

    // A pending request gives up only when the limit is reached with no ready.
    assign timed_out     = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT) && !memReady;
    assign entering_wait = (state_next != state) &&
                           ((state_next == S_FETCH) || (state_next == S_MEM));

    // Next-state and control decode; everything is held at zero during reset.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        // NOTE: combinational logic uses blocking '=' so later lines see the
        // defaults just written above.
        state_next      = state;
        trap_set        = 1'b0;
        trap_cause_next = 2'b00;
        memReq          = 1'b0;
        memWr           = 1'b0;
        addrSrc         = 1'b0;
        dmCtrl          = 3'b000;
        irWr            = 1'b0;
        pcWr            = 1'b0;
        pcSrc           = 1'b0;
        ruWr            = 1'b0;
        ruDataWrSrc     = 2'b00;
        aluASrc         = 1'b0;
        aluBSrc         = 1'b0;
        aluOp           = 4'b0000;
        immSrc          = 3'b000;
        retire          = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    memReq = 1'b1;
                    if (memReady) begin
                        irWr       = 1'b1;
                        pcWr       = 1'b1;
                        state_next = S_DECODE;
                    end else if (timed_out) begin
                        trap_set        = 1'b1;
                        trap_cause_next = CAUSE_TIMEOUT;
                        state_next      = S_TRAP;
                    end
                end
                S_DECODE: begin
                    case (opCode)
                        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_next = S_EXEC;
                        default: begin
                            trap_set        = 1'b1;
                            trap_cause_next = CAUSE_ILLEGAL;
                            state_next      = S_TRAP;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (opCode)
                        OP_R: begin
                            aluOp      = {func7[5], func3};
                            state_next = S_WB;
                        end
                        OP_I: begin
                            // Only the shift-right pair uses func7[5] as alt.
                            aluBSrc    = 1'b1;
                            aluOp      = {func7[5] & (func3 == 3'b101), func3};
                            state_next = S_WB;
                        end
                        OP_LOAD: begin
                            aluBSrc    = 1'b1;
                            state_next = S_MEM;
                        end
                        OP_STORE: begin
                            aluBSrc    = 1'b1;
                            immSrc     = 3'b001;
                            state_next = S_MEM;
                        end
                        OP_BRANCH: begin
                            aluASrc    = 1'b1;
                            aluBSrc    = 1'b1;
                            immSrc     = 3'b101;
                            pcSrc      = 1'b1;
                            pcWr       = brTaken;
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end
                        OP_JAL, OP_JALR: begin
                            aluASrc     = (opCode == OP_JAL);
                            aluBSrc     = 1'b1;
                            immSrc      = (opCode == OP_JAL) ? 3'b110 : 3'b000;
                            pcWr        = 1'b1;
                            pcSrc       = 1'b1;
                            ruWr        = 1'b1;
                            ruDataWrSrc = 2'b10;
                            retire      = 1'b1;
                            state_next  = S_FETCH;
                        end
                        OP_LUI: begin
                            ruWr        = 1'b1;
                            ruDataWrSrc = 2'b11;
                            immSrc      = 3'b010;
                            retire      = 1'b1;
                            state_next  = S_FETCH;
                        end
                        OP_AUIPC: begin
                            aluASrc    = 1'b1;
                            aluBSrc    = 1'b1;
                            immSrc     = 3'b010;
                            state_next = S_WB;
                        end
                        default: begin
                            trap_set        = 1'b1;
                            trap_cause_next = CAUSE_ILLEGAL;
                            state_next      = S_TRAP;
                        end
                    endcase
                end
                S_MEM: begin
                    memReq  = 1'b1;
                    addrSrc = 1'b1;
                    memWr   = (opCode == OP_STORE);
                    dmCtrl  = func3;
                    if (memReady) begin
                        if (opCode == OP_STORE) begin
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            state_next = S_WB;
                        end
                    end else if (timed_out) begin
                        trap_set        = 1'b1;
                        trap_cause_next = CAUSE_TIMEOUT;
                        state_next      = S_TRAP;
                    end
                end
                S_WB: begin
                    ruWr        = 1'b1;
                    ruDataWrSrc = (opCode == OP_LOAD) ? 2'b01 : 2'b00;
                    retire      = 1'b1;
                    state_next  = S_FETCH;
                end
                S_TRAP: begin
                    state_next = S_TRAP;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking '<=' so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Memory wait counter: cleared on entering FETCH/MEM, counts stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)                                             wait_cnt <= '0;
        else if (entering_wait)                              wait_cnt <= '0;
        else if (memReq && !memReady && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + INSTRET_W'(1);
    end

    // Sticky trap flag and cause; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap      <= 1'b0;
            trapCause <= 2'b00;
        end else if (trap_set) begin
            trap      <= 1'b1;
            trapCause <= trap_cause_next;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors checked
// against hand-written expectations; a second instance with a 2-bit counter
// and a 4-cycle timeout covers counter wrap and timeout boundaries.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       addr_src;
        logic [2:0] dm;
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_src;
        logic       ru_wr;
        logic [1:0] ru_src;
        logic       a_src;
        logic       b_src;
        logic [3:0] alu_op;
        logic [2:0] imm;
        logic       ret;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       br;
        logic       rdy;
        ctl_t       ex;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opCode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic brTaken = 1'b0;
    logic memReady = 1'b0;

    logic memReq, memWr, addrSrc, irWr, pcWr, pcSrc, ruWr, aluASrc, aluBSrc, retire, trap;
    logic [2:0] dmCtrl, immSrc;
    logic [1:0] ruDataWrSrc, trapCause;
    logic [3:0] aluOp;
    logic [31:0] instret;

    logic s_memReq, s_memWr, s_addrSrc, s_irWr, s_pcWr, s_pcSrc, s_ruWr, s_aluASrc, s_aluBSrc, s_retire, s_trap;
    logic [2:0] s_dmCtrl, s_immSrc;
    logic [1:0] s_ruDataWrSrc, s_trapCause;
    logic [3:0] s_aluOp;
    logic [1:0] s_instret;

    ctl_t act;
    assign act = {memReq, memWr, addrSrc, dmCtrl, irWr, pcWr, pcSrc, ruWr,
                  ruDataWrSrc, aluASrc, aluBSrc, aluOp, immSrc, retire};

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_ret = '0;

    multicycle_ctrl u_dut (
        .clk(clk), .rst(rst), .opCode(opCode), .func3(func3), .func7(func7),
        .brTaken(brTaken), .memReady(memReady), .memReq(memReq), .memWr(memWr),
        .addrSrc(addrSrc), .dmCtrl(dmCtrl), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc),
        .ruWr(ruWr), .ruDataWrSrc(ruDataWrSrc), .aluASrc(aluASrc), .aluBSrc(aluBSrc),
        .aluOp(aluOp), .immSrc(immSrc), .retire(retire), .instret(instret),
        .trap(trap), .trapCause(trapCause)
    );

    multicycle_ctrl #(.INSTRET_W(2), .MEM_TIMEOUT(4)) u_small (
        .clk(clk), .rst(rst), .opCode(opCode), .func3(func3), .func7(func7),
        .brTaken(brTaken), .memReady(memReady), .memReq(s_memReq), .memWr(s_memWr),
        .addrSrc(s_addrSrc), .dmCtrl(s_dmCtrl), .irWr(s_irWr), .pcWr(s_pcWr), .pcSrc(s_pcSrc),
        .ruWr(s_ruWr), .ruDataWrSrc(s_ruDataWrSrc), .aluASrc(s_aluASrc), .aluBSrc(s_aluBSrc),
        .aluOp(s_aluOp), .immSrc(s_immSrc), .retire(s_retire), .instret(s_instret),
        .trap(s_trap), .trapCause(s_trapCause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected-control constructors.
    function automatic ctl_t c_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_req = 1'b1;
        c.ir_wr   = rdy;
        c.pc_wr   = rdy;
        return c;
    endfunction

    function automatic ctl_t c_exec(input logic a, input logic b, input logic [3:0] op,
                                    input logic [2:0] imm, input logic pw, input logic ps,
                                    input logic rw, input logic [1:0] rs, input logic ret);
        ctl_t c = '0;
        c.a_src = a;  c.b_src = b;  c.alu_op = op; c.imm = imm;
        c.pc_wr = pw; c.pc_src = ps; c.ru_wr = rw; c.ru_src = rs; c.ret = ret;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic wr, input logic [2:0] f3, input logic ret);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.addr_src = 1'b1; c.mem_wr = wr; c.dm = f3; c.ret = ret;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic [1:0] rs);
        ctl_t c = '0;
        c.ru_wr = 1'b1; c.ru_src = rs; c.ret = 1'b1;
        return c;
    endfunction

    function automatic step_t st(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic br, input logic rdy, input ctl_t ex);
        step_t s;
        s.op = op; s.f3 = f3; s.f7 = f7; s.br = br; s.rdy = rdy; s.ex = ex;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; memReady = 1'b1; opCode = 7'b0110011;
        tick(); tick();
        #1;
        n_cmp++; if (act !== '0) begin $display("FAIL reset_ctl: got %h want 0", act); n_err++; end
        n_cmp++; if (instret !== 32'd0) begin $display("FAIL reset_instret: got %0d want 0", instret); n_err++; end
        n_cmp++; if (trap !== 1'b0 || trapCause !== 2'b00) begin
            $display("FAIL reset_trap: got %b/%b want 0/00", trap, trapCause); n_err++; end
        rst = 1'b0;
        #1;
        n_cmp++; if (act !== c_fetch(1'b1)) begin $display("FAIL first_fetch: got %h want %h", act, c_fetch(1'b1)); n_err++; end
    endtask

    task automatic test_alu();
        step_t q[$];
        logic [6:0] ops [5] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010111};
        logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000};
        logic [6:0] f7s [5] = '{7'b0000000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0000000};
        ctl_t exs [5];
        exs[0] = c_exec(0, 0, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0);  // add
        exs[1] = c_exec(0, 0, 4'b1000, 3'b000, 0, 0, 0, 2'b00, 0);  // sub
        exs[2] = c_exec(0, 1, 4'b1101, 3'b000, 0, 0, 0, 2'b00, 0);  // srai
        exs[3] = c_exec(0, 1, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0);  // addi, func7[5] ignored
        exs[4] = c_exec(1, 1, 4'b0000, 3'b010, 0, 0, 0, 2'b00, 0);  // auipc
        for (int k = 0; k < 5; k++) begin
            q.push_back(st(ops[k], f3s[k], f7s[k], 0, 1, c_fetch(1'b1)));
            q.push_back(st(ops[k], f3s[k], f7s[k], 0, 1, '0));
            q.push_back(st(ops[k], f3s[k], f7s[k], 0, 1, exs[k]));
            q.push_back(st(ops[k], f3s[k], f7s[k], 0, 1, c_wb(2'b00)));
        end
        foreach (q[i]) begin
            opCode = q[i].op; func3 = q[i].f3; func7 = q[i].f7; brTaken = q[i].br; memReady = q[i].rdy;
            #2;
            n_cmp++; if (act !== q[i].ex) begin $display("FAIL alu[%0d]: got %h want %h", i, act, q[i].ex); n_err++; end
            tick();
        end
        exp_ret += 5;
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL alu_instret: got %0d want %0d", instret, exp_ret); n_err++; end
    endtask

    task automatic test_load();
        step_t q[$];
        q.push_back(st(7'b0000011, 3'b010, 0, 0, 1, c_fetch(1'b1)));
        q.push_back(st(7'b0000011, 3'b010, 0, 0, 1, '0));
        q.push_back(st(7'b0000011, 3'b010, 0, 0, 1, c_exec(0, 1, 4'b0000, 3'b000, 0, 0, 0, 2'b00, 0)));
        for (int k = 0; k < 3; k++) q.push_back(st(7'b0000011, 3'b010, 0, 0, 0, c_mem(0, 3'b010, 0)));
        q.push_back(st(7'b0000011, 3'b010, 0, 0, 1, c_mem(0, 3'b010, 0)));
        q.push_back(st(7'b0000011, 3'b010, 0, 0, 0, c_wb(2'b01)));
        foreach (q[i]) begin
            opCode = q[i].op; func3 = q[i].f3; func7 = q[i].f7; brTaken = q[i].br; memReady = q[i].rdy;
            #2;
            n_cmp++; if (act !== q[i].ex) begin $display("FAIL load[%0d]: got %h want %h", i, act, q[i].ex); n_err++; end
            tick();
        end
        exp_ret += 1;
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL load_instret: got %0d want %0d", instret, exp_ret); n_err++; end
    endtask

    task automatic test_store_branch();
        step_t q[$];
        q.push_back(st(7'b0100011, 3'b010, 0, 0, 1, c_fetch(1'b1)));
        q.push_back(st(7'b0100011, 3'b010, 0, 0, 1, '0));
        q.push_back(st(7'b0100011, 3'b010, 0, 0, 1, c_exec(0, 1, 4'b0000, 3'b001, 0, 0, 0, 2'b00, 0)));
        q.push_back(st(7'b0100011, 3'b010, 0, 0, 1, c_mem(1, 3'b010, 1)));
        for (int b = 0; b < 2; b++) begin
            q.push_back(st(7'b1100011, 3'b000, 0, b[0], 1, c_fetch(1'b1)));
            q.push_back(st(7'b1100011, 3'b000, 0, b[0], 1, '0));
            q.push_back(st(7'b1100011, 3'b000, 0, b[0], 1, c_exec(1, 1, 4'b0000, 3'b101, b[0], 1, 0, 2'b00, 1)));
        end
        foreach (q[i]) begin
            opCode = q[i].op; func3 = q[i].f3; func7 = q[i].f7; brTaken = q[i].br; memReady = q[i].rdy;
            #2;
            n_cmp++; if (act !== q[i].ex) begin $display("FAIL st_br[%0d]: got %h want %h", i, act, q[i].ex); n_err++; end
            tick();
        end
        brTaken = 1'b0;
        exp_ret += 3;
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL st_br_instret: got %0d want %0d", instret, exp_ret); n_err++; end
    endtask

    task automatic test_jump();
        step_t q[$];
        logic [6:0] ops [3] = '{7'b1101111, 7'b1100111, 7'b0110111};
        ctl_t exs [3];
        exs[0] = c_exec(1, 1, 4'b0000, 3'b110, 1, 1, 1, 2'b10, 1);  // jal
        exs[1] = c_exec(0, 1, 4'b0000, 3'b000, 1, 1, 1, 2'b10, 1);  // jalr
        exs[2] = c_exec(0, 0, 4'b0000, 3'b010, 0, 0, 1, 2'b11, 1);  // lui
        for (int k = 0; k < 3; k++) begin
            q.push_back(st(ops[k], 3'b000, 0, 0, 1, c_fetch(1'b1)));
            q.push_back(st(ops[k], 3'b000, 0, 0, 1, '0));
            q.push_back(st(ops[k], 3'b000, 0, 0, 1, exs[k]));
        end
        foreach (q[i]) begin
            opCode = q[i].op; func3 = q[i].f3; func7 = q[i].f7; brTaken = q[i].br; memReady = q[i].rdy;
            #2;
            n_cmp++; if (act !== q[i].ex) begin $display("FAIL jump[%0d]: got %h want %h", i, act, q[i].ex); n_err++; end
            tick();
        end
        exp_ret += 3;
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL jump_instret: got %0d want %0d", instret, exp_ret); n_err++; end
        n_cmp++; if (s_instret !== exp_ret[1:0]) begin $display("FAIL small_instret: got %0d want %0d", s_instret, exp_ret[1:0]); n_err++; end
    endtask

    task automatic test_illegal();
        opCode = 7'b1111111; func3 = 3'b000; func7 = 7'b0; memReady = 1'b1;
        tick();  // FETCH
        #1;
        n_cmp++; if (act !== '0) begin $display("FAIL illegal_decode: got %h want 0", act); n_err++; end
        tick();  // DECODE -> TRAP
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (act !== '0) begin $display("FAIL illegal_quiet[%0d]: got %h want 0", k, act); n_err++; end
            tick();
        end
        n_cmp++; if (trap !== 1'b1 || trapCause !== 2'b01) begin
            $display("FAIL illegal_cause: got %b/%b want 1/01", trap, trapCause); n_err++; end
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL illegal_instret: got %0d want %0d", instret, exp_ret); n_err++; end
        rst = 1'b1; tick(); rst = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_timeout();
        opCode = 7'b0110011; func3 = 3'b000; func7 = 7'b0; memReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (s_memReq !== 1'b1 || memReq !== 1'b1) begin
                $display("FAIL timeout_wait[%0d]: got %b/%b want 1/1", k, s_memReq, memReq); n_err++; end
            tick();
        end
        #1;
        n_cmp++; if (s_trap !== 1'b1 || s_trapCause !== 2'b10 || s_memReq !== 1'b0) begin
            $display("FAIL timeout_trap: got %b/%b/%b want 1/10/0", s_trap, s_trapCause, s_memReq); n_err++; end
        n_cmp++; if (trap !== 1'b0 || memReq !== 1'b1) begin
            $display("FAIL timeout_main_waits: got %b/%b want 0/1", trap, memReq); n_err++; end
        rst = 1'b1; tick(); rst = 1'b0;
        // Ready on the limit cycle completes the fetch without a trap.
        for (int k = 0; k < 4; k++) tick();
        memReady = 1'b1;
        #1;
        n_cmp++; if (s_irWr !== 1'b1) begin $display("FAIL limit_ready_irwr: got %b want 1", s_irWr); n_err++; end
        tick();
        #1;
        n_cmp++; if (s_trap !== 1'b0 || s_memReq !== 1'b0) begin
            $display("FAIL limit_ready_notrap: got %b/%b want 0/0", s_trap, s_memReq); n_err++; end
        rst = 1'b1; tick(); rst = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_reset_mid_mem();
        opCode = 7'b0000011; func3 = 3'b010; func7 = 7'b0; memReady = 1'b1;
        tick(); tick(); tick();  // FETCH, DECODE, EXEC
        memReady = 1'b0;
        #1;
        n_cmp++; if (act !== c_mem(0, 3'b010, 0)) begin $display("FAIL midmem_wait: got %h want %h", act, c_mem(0, 3'b010, 0)); n_err++; end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (memReq !== 1'b0 || act !== '0) begin $display("FAIL midmem_rst_drop: got %h want 0", act); n_err++; end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (memReq !== 1'b1 || addrSrc !== 1'b0) begin
            $display("FAIL midmem_refetch: got %b/%b want 1/0", memReq, addrSrc); n_err++; end
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL midmem_instret: got %0d want %0d", instret, exp_ret); n_err++; end
    endtask

    task automatic test_wrap();
        logic [1:0] s_exp = 2'd0;
        opCode = 7'b0110111; func3 = 3'b000; func7 = 7'b0; memReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); tick(); tick();  // LUI: FETCH, DECODE, EXEC
            s_exp = s_exp + 2'd1;
            exp_ret += 1;
            n_cmp++; if (s_instret !== s_exp) begin $display("FAIL wrap[%0d]: got %0d want %0d", k, s_instret, s_exp); n_err++; end
        end
        n_cmp++; if (instret !== exp_ret) begin $display("FAIL wrap_main: got %0d want %0d", instret, exp_ret); n_err++; end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_branch();
        test_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
